gbf_port_agent: RTL and testbench

- Initiator side of one global-buffer (GBF) quad-port RAM port. The RAM has combinational read and synchronous write.
- Executes burst commands: read N words into a valid/ready output stream, or write N words from a valid/ready input stream.
- Drives the RAM port's addr/we/data directly. One agent per port; up to four agents share one RAM.
- Feeds weights and inputs to the PE array and writes results back.

---
 rtl/gbf_pkg.sv | 30 +++
 rtl/gbf_skid_fifo.sv | 48 ++++
 rtl/gbf_port_agent.sv | 155 +++++++++++++++
 tb/tb_gbf_port_agent.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbf_pkg.sv
// rtl/gbf_pkg.sv - shared state type and sizing/address helpers for the GBF port agent
package gbf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } agent_state_t;

    function automatic int gbf_aw(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    function automatic int gbf_lw(input int height);
        return $clog2(height + 1);
    endfunction

    // Wrapping step; a single subtraction suffices because addr and stride are both below height.
    function automatic int gbf_addr_next(input int addr, input int stride, input int height);
        int n;
        n = addr + stride;
        if (n >= height) begin
            n = n - height;
        end
        return n;
    endfunction

endpackage

// File: rtl/gbf_skid_fifo.sv
// rtl/gbf_skid_fifo.sv - 2-entry valid/ready buffer between the RAM read port and the read stream
module gbf_skid_fifo #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    assign m_tvalid = (count != 2'd0);
    // A full buffer still takes a beat in the same cycle the head leaves.
    assign s_tready = (count != 2'd2) || m_tready;
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/gbf_port_agent.sv
// rtl/gbf_port_agent.sv - burst read/write initiator for one GBF RAM port; GBF_AGENT_STRIDE_EN adds cmd_stride
module gbf_port_agent
    import gbf_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int HEIGHT = 48,
    localparam int AW     = gbf_aw(HEIGHT),
    localparam int LW     = gbf_lw(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LW-1:0]    cmd_len,
`ifdef GBF_AGENT_STRIDE_EN
    input  logic [AW-1:0]    cmd_stride,
`endif
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_q,
    output logic             busy,
    output logic             done
);

    agent_state_t   state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  addr_next;
    logic [AW-1:0]  addr_hold_q;
    logic [AW-1:0]  stride;
    logic [LW-1:0]  remaining_q;
    logic           last_beat;
    logic           rd_issue;
    logic           fifo_s_tready;
    logic [WIDTH:0] fifo_m_tdata;

`ifdef GBF_AGENT_STRIDE_EN
    logic [AW-1:0]  stride_q;
    assign stride = stride_q;
`else
    assign stride = AW'(1);
`endif

    assign addr_next = AW'(gbf_addr_next(int'(addr_q), int'(stride), HEIGHT));
    assign last_beat = (remaining_q == LW'(1));
    assign busy      = (state_q != IDLE);
    // The bus follows the live address only while beats are being issued.
    assign ram_addr  = (state_q == READ || state_q == WRITE) ? addr_q : addr_hold_q;
    assign rd_last   = fifo_m_tdata[WIDTH];
    assign rd_data   = fifo_m_tdata[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rd_issue  = 1'b0;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rd_issue = fifo_s_tready;
                if (rd_issue && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_valid) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                wr_ready  = 1'b1;
                ram_we    = wr_valid;
                ram_wdata = wr_data;
                if (wr_valid && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            addr_hold_q <= '0;
            remaining_q <= '0;
`ifdef GBF_AGENT_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            addr_hold_q <= ram_addr;
            if (cmd_ready && cmd_valid) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
`ifdef GBF_AGENT_STRIDE_EN
                stride_q    <= cmd_stride;
`endif
            end else if (rd_issue || (state_q == WRITE && wr_valid)) begin
                addr_q      <= addr_next;
                remaining_q <= remaining_q - LW'(1);
            end
        end
    end

    gbf_skid_fifo #(
        .DW(WIDTH + 1)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (rd_issue),
        .s_tready (fifo_s_tready),
        .s_tdata  ({last_beat, ram_q}),
        .m_tvalid (rd_valid),
        .m_tready (rd_ready),
        .m_tdata  (fifo_m_tdata)
    );

endmodule

// File: tb/tb_gbf_port_agent.sv
// tb/tb_gbf_port_agent.sv - randomized self-checking bench for gbf_port_agent against an array model
module tb_gbf_port_agent;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 48;
    localparam int AW     = 6;
    localparam int LW     = 6;
    localparam int BUDGET = 600;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [LW-1:0]    cmd_len;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_q;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] ram       [HEIGHT];
    logic [WIDTH-1:0] model_mem [HEIGHT];
    logic [WIDTH-1:0] wbuf      [HEIGHT];
    logic             preload;

    int checks = 0;
    int errors = 0;

    gbf_port_agent #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_q     (ram_q),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < HEIGHT; i++) ram[i] <= WIDTH'(i + 256);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
    end
    assign ram_q = ram[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_pat(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 1;
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic issue_cmd(input logic wr, input int a, input int n);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(n);
        @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 0);
        chk({tag, "_idle_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_read(input int a, input int n, input int mode);
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] held;
        logic             held_last;
        logic             stalled;
        int               got;
        int               dones;
        int               k;
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(a + i) % HEIGHT]);
        got     = 0;
        dones   = 0;
        stalled = 1'b0;
        held    = '0;
        held_last = 1'b0;
        rd_ready = 1'b1;
        issue_cmd(1'b0, a, n);
        for (k = 1; k <= BUDGET && dones == 0; k++) begin
            rd_ready = ready_pat(mode, k);
            @(negedge clk);
            if (k == 1) begin
                chk("rd_t1_valid", 32'(rd_valid), 0);
                if (n > 0) chk("rd_t1_addr", 32'(ram_addr), a);
            end
            if (k == 2 && n > 0 && mode == 0) chk("rd_t2_valid", 32'(rd_valid), 1);
            chk("rd_we_low", 32'(ram_we), 0);
            if (stalled) begin
                chk("rd_stall_valid", 32'(rd_valid), 1);
                chk("rd_stall_data", rd_data, held);
                chk("rd_stall_last", 32'(rd_last), 32'(held_last));
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rd_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e);
                    chk("rd_last", 32'(rd_last), 32'(exp_q.size() == 0));
                    if (mode == 0) chk("rd_beat_cycle", k, got + 2);
                    got++;
                end
            end
            stalled   = rd_valid && !rd_ready;
            held      = rd_data;
            held_last = rd_last;
            if (done) begin
                dones++;
                if (n == 0) chk("zero_done_cycle", k, 1);
            end
            @(posedge clk); #1;
        end
        if (dones == 0) chk("rd_timeout", 0, 1);
        chk("rd_beats", got, n);
        rd_ready = 1'b0;
        finish_cmd("rd");
    endtask

    task automatic run_write(input int a, input int n, input int mode);
        int idx;
        int dones;
        int k;
        idx   = 0;
        dones = 0;
        issue_cmd(1'b1, a, n);
        for (k = 1; k <= BUDGET && dones == 0; k++) begin
            wr_valid = (idx < n) && (mode == 0 || (mode == 1 && k != 2) ||
                                     (mode == 2 && $urandom_range(0, 1) == 1));
            wr_data  = (idx < n) ? wbuf[idx] : WIDTH'($urandom);
            @(negedge clk);
            if (!wr_valid) chk("wr_we_gap", 32'(ram_we), 0);
            chk("wr_rd_valid", 32'(rd_valid), 0);
            if (wr_valid && wr_ready) begin
                chk("wr_we", 32'(ram_we), 1);
                chk("wr_addr", 32'(ram_addr), (a + idx) % HEIGHT);
                chk("wr_wdata", ram_wdata, wbuf[idx]);
                model_mem[(a + idx) % HEIGHT] = wbuf[idx];
                idx++;
            end
            if (done) begin
                dones++;
                if (n == 0) chk("zero_done_cycle", k, 1);
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        if (dones == 0) chk("wr_timeout", 0, 1);
        chk("wr_beats", idx, n);
        finish_cmd("wr");
    endtask

    task automatic check_ram();
        for (int i = 0; i < HEIGHT; i++) chk("ram_contents", ram[i], model_mem[i]);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        preload   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rd_ready  = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        for (int i = 0; i < HEIGHT; i++) model_mem[i] = WIDTH'(i + 256);
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_read(5, 4, 0);
        run_read(46, 4, 0);
        run_read(3, 6, 1);

        wbuf[0] = 32'hA;
        wbuf[1] = 32'hB;
        wbuf[2] = 32'hC;
        run_write(10, 3, 1);
        chk("wr_ram10", ram[10], 32'hA);
        chk("wr_ram11", ram[11], 32'hB);
        chk("wr_ram12", ram[12], 32'hC);

        run_read(0, 0, 0);
        run_write(7, 0, 0);

        rd_ready = 1'b1;
        issue_cmd(1'b0, 20, 8);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_mid_pre_valid", 32'(rd_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_valid", 32'(rd_valid), 0);
        chk("rst_mid_ram_we", 32'(ram_we), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rel_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rel_done", 32'(done), 0);
        @(posedge clk); #1;
        run_read(0, 2, 0);

        for (int t = 0; t < 14; t++) begin
            int a, n, mode;
            a    = $urandom_range(0, HEIGHT - 1);
            n    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : $urandom_range(1, HEIGHT);
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < HEIGHT; i++) wbuf[i] = WIDTH'($urandom);
                run_write(a, n, mode);
            end else begin
                run_read(a, n, mode);
            end
        end
        check_ram();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
